// File: rtl/fir_param_core.sv
// Parameterised direct-form FIR: programmable coefficient bank, registered products,
// then a registered adder tree with round-half-up, saturation and a clip flag.
module fir_param_core #(
    parameter  int TAPS  = 8,
    parameter  int DW    = 16,
    parameter  int CW    = 8,
    parameter  int OW    = 16,
    parameter  int SHIFT = 4,
    localparam int AW    = DW + CW + $clog2(TAPS),
    localparam int ABW   = $clog2(TAPS)
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    input  logic                 coef_we,
    input  logic [ABW-1:0]       coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_data,
    output logic                 sat_flag
);

    localparam int PW = DW + CW;
    localparam logic signed [CW-1:0] COEF_RST = CW'(2 ** (CW - 4));
    localparam logic signed [AW:0]   RND_ADD  = (AW + 1)'((2 ** SHIFT) / 2);
    localparam logic signed [AW:0]   OMAX     = (AW + 1)'((2 ** (OW - 1)) - 1);
    localparam logic signed [AW:0]   OMIN     = ~OMAX;

    logic signed [CW-1:0] coef_q [TAPS];
    logic signed [CW-1:0] coef_d [TAPS];
    logic signed [DW-1:0] dly_q  [TAPS-1];
    logic signed [DW-1:0] dly_d  [TAPS-1];
    logic signed [PW-1:0] prod_q [TAPS];
    logic signed [PW-1:0] prod_d [TAPS];
    logic                 v1_q, v1_d;
    logic                 out_valid_q, out_valid_d;
    logic signed [OW-1:0] out_data_q, out_data_d;
    logic                 sat_q, sat_d;
    logic                 addr_ok;
    logic signed [AW-1:0] acc;
    logic signed [AW:0]   rnd;

    // A non-power-of-two tap count leaves unused addresses that must not write.
    if (TAPS == (1 << ABW)) begin : g_addr_full
        assign addr_ok = 1'b1;
    end else begin : g_addr_part
        assign addr_ok = (int'(coef_addr) < TAPS);
    end

    always_comb begin
        coef_d = coef_q;
        if (coef_we && addr_ok) begin
            coef_d[coef_addr] = coef_data;
        end

        dly_d = dly_q;
        if (in_valid) begin
            dly_d[0] = in_data;
            for (int k = 1; k < TAPS - 1; k++) begin
                dly_d[k] = dly_q[k-1];
            end
        end

        // Products read the current coefficients, so a same-cycle write lands one sample later.
        prod_d[0] = PW'(in_data) * PW'(coef_q[0]);
        for (int k = 1; k < TAPS; k++) begin
            prod_d[k] = PW'(dly_q[k-1]) * PW'(coef_q[k]);
        end
        v1_d = in_valid;

        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc = acc + AW'(prod_q[k]);
        end
        rnd = ((AW + 1)'(acc) + RND_ADD) >>> SHIFT;

        out_valid_d = v1_q;
        out_data_d  = out_data_q;
        sat_d       = sat_q;
        if (v1_q) begin
            if (rnd > OMAX) begin
                out_data_d = OW'(OMAX);
                sat_d      = 1'b1;
            end else if (rnd < OMIN) begin
                out_data_d = OW'(OMIN);
                sat_d      = 1'b1;
            end else begin
                out_data_d = OW'(rnd);
                sat_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            coef_q      <= '{default: COEF_RST};
            dly_q       <= '{default: '0};
            prod_q      <= '{default: '0};
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            coef_q      <= coef_d;
            dly_q       <= dly_d;
            prod_q      <= prod_d;
            v1_q        <= v1_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_q       <= sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_flag  = sat_q;

endmodule
